// File: rtl/alu_op_sequencer.sv
// Initiator for a combinational 32-bit ALU: decodes MIPS ALUOp/funct, holds operands for
// SETTLE_CYCLES cycles, then returns the captured result over a valid/ready response channel.
module alu_op_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_illegal
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [2:0] dec_op;
  logic       dec_illegal;
  logic       accept;

  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (req_aluop)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (req_funct)
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b101010: dec_op = OP_SLT;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = dec_illegal ? RESP : SETTLE;
      SETTLE:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // Illegal requests bypass the ALU entirely, so its inputs keep their last legal values.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= OP_AND;
      cnt          <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      if (accept) begin
        if (dec_illegal) begin
          rsp_result   <= '0;
          rsp_overflow <= 1'b0;
          rsp_zero     <= 1'b0;
          rsp_illegal  <= 1'b1;
        end else begin
          alu_a  <= req_a;
          alu_b  <= req_b;
          alu_op <= dec_op;
          cnt    <= CNT_INIT;
        end
      end else if (state == SETTLE) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_result   <= alu_out;
          rsp_overflow <= alu_overflow && (alu_op == OP_ADD || alu_op == OP_SUB);
          rsp_zero     <= alu_zero;
          rsp_illegal  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the operand side.
module tb_alu_op_sequencer;
  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready;
  logic [W-1:0] req_a, req_b;
  logic [1:0]   req_aluop;
  logic [5:0]   req_funct;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_op;
  logic         alu_overflow, alu_zero;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_overflow, rsp_zero, rsp_illegal;

  int checks   = 0;
  int failures = 0;
  int lat;
  int seen;

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_aluop(req_aluop), .req_funct(req_funct),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  // ALU model; overflow is driven high for logic ops so the sequencer's masking is visible.
  always_comb begin
    alu_out      = '0;
    alu_overflow = 1'b1;
    case (alu_op)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: begin
        alu_out      = alu_a + alu_b;
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      3'b110: begin
        alu_out      = alu_a - alu_b;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
      end
      3'b111: alu_out = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly the accept edge, then scramble the inputs.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [5:0] f);
    check("pre_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_aluop = op;
    req_funct = f;
    step();
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = ~b;
    req_funct = ~f;
  endtask

  // Edges counted after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    check("done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("done_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_aluop = 2'b00; req_funct = '0; rsp_ready = 1'b1;
    step(); step();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_alu_op", {29'b0, alu_op}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    reset = 1'b0;
    step();

    // 1: R-type ADD overflow
    send(32'h7FFFFFFF, 32'h7FFFFFFF, 2'b10, 6'b100000);
    check("t1_alu_op", {29'b0, alu_op}, 32'h2);
    check("t1_alu_a", alu_a, 32'h7FFFFFFF);
    wait_rsp(lat);
    check("t1_latency", lat, S);
    check("t1_result", rsp_result, 32'hFFFFFFFE);
    check("t1_ovf", {31'b0, rsp_overflow}, 32'd1);
    check("t1_zero", {31'b0, rsp_zero}, 32'd0);
    check("t1_illegal", {31'b0, rsp_illegal}, 32'd0);
    finish_rsp();

    // 2: beq SUB to zero
    send(32'h5, 32'h5, 2'b01, 6'b000000);
    check("t2_alu_op", {29'b0, alu_op}, 32'h6);
    wait_rsp(lat);
    check("t2_latency", lat, S);
    check("t2_result", rsp_result, 32'd0);
    check("t2_zero", {31'b0, rsp_zero}, 32'd1);
    check("t2_ovf", {31'b0, rsp_overflow}, 32'd0);
    check("t2_illegal", {31'b0, rsp_illegal}, 32'd0);
    finish_rsp();

    // 3: illegal funct; ALU side keeps the SUB operands
    send(32'h1, 32'h2, 2'b10, 6'b000000);
    wait_rsp(lat);
    check("t3_latency", lat, 0);
    check("t3_illegal", {31'b0, rsp_illegal}, 32'd1);
    check("t3_result", rsp_result, 32'd0);
    check("t3_zero", {31'b0, rsp_zero}, 32'd0);
    check("t3_alu_op", {29'b0, alu_op}, 32'h6);
    check("t3_alu_a", alu_a, 32'h5);
    check("t3_alu_b", alu_b, 32'h5);
    finish_rsp();

    // aluop 11 is illegal too
    send(32'h3, 32'h4, 2'b11, 6'b100000);
    wait_rsp(lat);
    check("t3b_illegal", {31'b0, rsp_illegal}, 32'd1);
    check("t3b_alu_op", {29'b0, alu_op}, 32'h6);
    finish_rsp();

    // 4: AND with response backpressure; ALU overflow must be masked
    rsp_ready = 1'b0;
    send(32'hF0F0F0F0, 32'h00FF00FF, 2'b10, 6'b100100);
    wait_rsp(lat);
    check("t4_latency", lat, S);
    for (int i = 0; i < 5; i++) begin
      check("t4_valid_hold", {31'b0, rsp_valid}, 32'd1);
      check("t4_result_hold", rsp_result, 32'h00F000F0);
      check("t4_ovf", {31'b0, rsp_overflow}, 32'd0);
      check("t4_req_ready", {31'b0, req_ready}, 32'd0);
      step();
    end
    finish_rsp();

    // lw/sw add
    send(32'h1, 32'h2, 2'b00, 6'b111111);
    check("t_add_alu_op", {29'b0, alu_op}, 32'h2);
    wait_rsp(lat);
    check("t_add_result", rsp_result, 32'h3);
    finish_rsp();

    // 6: SLT signed compare
    send(32'hFFFFFFFF, 32'h00000001, 2'b10, 6'b101010);
    check("t6_alu_op", {29'b0, alu_op}, 32'h7);
    wait_rsp(lat);
    check("t6_result", rsp_result, 32'h1);
    check("t6_ovf", {31'b0, rsp_overflow}, 32'd0);
    check("t6_zero", {31'b0, rsp_zero}, 32'd0);
    finish_rsp();

    // OR
    send(32'h0000F000, 32'h0000000F, 2'b10, 6'b100101);
    check("t_or_alu_op", {29'b0, alu_op}, 32'h1);
    wait_rsp(lat);
    check("t_or_result", rsp_result, 32'h0000F00F);
    finish_rsp();

    // 5: reset during the first SETTLE cycle of a SUB
    send(32'h9, 32'h3, 2'b01, 6'b000000);
    reset = 1'b1;
    step();
    check("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t5_req_ready", {31'b0, req_ready}, 32'd1);
    check("t5_alu_op", {29'b0, alu_op}, 32'd0);
    check("t5_alu_a", alu_a, 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen++;
      step();
    end
    check("t5_no_rsp", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
